// File: rtl/led_shift_counter_pkg.sv
`default_nettype none
// ============================================================================
// led_shift_counter_pkg : shared widths, switch encoding and LED reset pattern
// Revision : 1.0
// ============================================================================
package led_shift_counter_pkg;

  localparam int NB_LEDS_DEF    = 4;
  localparam int NB_SW_DEF      = 3;
  localparam int NB_COUNTER_DEF = 8;

  // Switch field layout: bit 0 enables counting, bits 2:1 pick the rate.
  localparam int SW_EN_BIT  = 0;
  localparam int SW_SEL_LSB = 1;
  localparam int SW_SEL_MSB = 2;

  localparam logic [1:0] SEL_R0 = 2'b00;
  localparam logic [1:0] SEL_R1 = 2'b01;
  localparam logic [1:0] SEL_R2 = 2'b10;
  localparam logic [1:0] SEL_R3 = 2'b11;

  // LED pattern after reset: only bit 0 lit.
  localparam int LED_RESET_PATTERN = 1;

endpackage : led_shift_counter_pkg
`default_nettype wire

// File: rtl/led_shift_counter_rate_counter.sv
`default_nettype none
// ============================================================================
// rate_counter : switch-selected terminal count, emits a registered 1-cycle tick
// Revision : 1.0
// ============================================================================
module rate_counter
  import led_shift_counter_pkg::*;
#(
  parameter int NB_SW      = NB_SW_DEF,
  parameter int NB_COUNTER = NB_COUNTER_DEF,
  parameter int R0_LIMIT   = 2**NB_COUNTER - 1,
  parameter int R1_LIMIT   = 2**(NB_COUNTER-1) - 1,
  parameter int R2_LIMIT   = 2**(NB_COUNTER-2) - 1,
  parameter int R3_LIMIT   = 2**(NB_COUNTER-3) - 1
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic             o_valid
);

  logic [NB_COUNTER-1:0] limit;
  logic [NB_COUNTER-1:0] count_d, count_q;
  logic                  valid_d, valid_q;

  always_comb begin
    limit = NB_COUNTER'(R0_LIMIT);
    case (i_sw[SW_SEL_MSB:SW_SEL_LSB])
      SEL_R0: limit = NB_COUNTER'(R0_LIMIT);
      SEL_R1: limit = NB_COUNTER'(R1_LIMIT);
      SEL_R2: limit = NB_COUNTER'(R2_LIMIT);
      SEL_R3: limit = NB_COUNTER'(R3_LIMIT);
    endcase
  end

  // >= rather than == so a rate change to a smaller limit wraps at once
  // instead of running the counter all the way round.
  always_comb begin
    count_d = count_q;
    valid_d = 1'b0;
    if (i_sw[SW_EN_BIT]) begin
      if (count_q >= limit) begin
        count_d = '0;
        valid_d = 1'b1;
      end else begin
        count_d = count_q + NB_COUNTER'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;

endmodule : rate_counter
`default_nettype wire

// File: rtl/led_shift_counter.sv
`default_nettype none
// ============================================================================
// led_shift_counter : switch-controlled LED chaser, rotates a one-hot LED per tick
// Revision : 1.0
// ============================================================================
module led_shift_counter
  import led_shift_counter_pkg::*;
#(
  parameter int NB_LEDS    = NB_LEDS_DEF,
  parameter int NB_SW      = NB_SW_DEF,
  parameter int NB_COUNTER = NB_COUNTER_DEF,
  parameter int R0_LIMIT   = 2**NB_COUNTER - 1,
  parameter int R1_LIMIT   = 2**(NB_COUNTER-1) - 1,
  parameter int R2_LIMIT   = 2**(NB_COUNTER-2) - 1,
  parameter int R3_LIMIT   = 2**(NB_COUNTER-3) - 1
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_valid
);

  logic               tick;
  logic [NB_LEDS-1:0] led_d, led_q;

  rate_counter #(
    .NB_SW      (NB_SW),
    .NB_COUNTER (NB_COUNTER),
    .R0_LIMIT   (R0_LIMIT),
    .R1_LIMIT   (R1_LIMIT),
    .R2_LIMIT   (R2_LIMIT),
    .R3_LIMIT   (R3_LIMIT)
  ) u_rate_counter (
    .clock   (clock),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .o_valid (tick)
  );

  // Rotation only, never a load: the pattern stays one-hot from reset onward.
  always_comb begin
    led_d = led_q;
    if (tick) begin
      led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      led_q <= NB_LEDS'(LED_RESET_PATTERN);
    end else begin
      led_q <= led_d;
    end
  end

  assign o_led   = led_q;
  assign o_valid = tick;

endmodule : led_shift_counter
`default_nettype wire

// File: tb/tb_led_shift_counter.sv
`default_nettype none
// ============================================================================
// tb_led_shift_counter : directed vectors for the LED chaser, self-checking
// Revision : 1.0
// ============================================================================
module tb_led_shift_counter;

  logic       clock;
  logic       i_reset;
  logic [2:0] i_sw;
  logic [3:0] o_led;
  logic       o_valid;

  int         n_vec;
  int         n_err;
  logic [3:0] exp_led;

  led_shift_counter #(
    .NB_LEDS    (4),
    .NB_SW      (3),
    .NB_COUNTER (8)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .o_led   (o_led),
    .o_valid (o_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  // Number of edges until o_valid is seen high; -1 when the bound expires.
  task automatic wait_tick(input int max_cyc, output int n);
    n = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clock);
      if (o_valid === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  // Waits for a tick, checks its spacing, then checks the LED moves one edge later.
  task automatic tick_and_step(input string tag, input int exp_n, input logic [2:0] sw_next);
    int n;
    wait_tick(400, n);
    check({tag, "_gap"}, n, exp_n);
    check({tag, "_led_hold"}, {28'd0, o_led}, {28'd0, exp_led});
    i_sw = sw_next;
    @(negedge clock);
    exp_led = {exp_led[2:0], exp_led[3]};
    check({tag, "_valid_width"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_led_step"}, {28'd0, o_led}, {28'd0, exp_led});
  endtask

  initial begin
    int seen;
    n_vec   = 0;
    n_err   = 0;
    exp_led = 4'b0001;
    i_reset = 1'b1;
    i_sw    = 3'b111;

    // Reset asserted before the first edge must clear outputs immediately.
    #1 i_reset = 1'b0;
    #1;
    check("rst_async_led", {28'd0, o_led}, 32'd1);
    check("rst_async_valid", {31'd0, o_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("rst_hold_led", {28'd0, o_led}, 32'd1);
      check("rst_hold_valid", {31'd0, o_valid}, 32'd0);
    end
    i_reset = 1'b1;

    // Rate 3: period 32 edges.
    tick_and_step("r3_p1", 32, 3'b111);
    tick_and_step("r3_p2", 31, 3'b111);
    tick_and_step("r3_p3", 31, 3'b111);
    tick_and_step("r3_p4", 31, 3'b111);

    // Two more steps, then reset between edges.
    tick_and_step("r3_p5", 31, 3'b111);
    tick_and_step("r3_p6", 31, 3'b111);
    check("pre_rst_led", {28'd0, o_led}, 32'd4);
    #2 i_reset = 1'b0;
    #1;
    exp_led = 4'b0001;
    check("mid_rst_led", {28'd0, o_led}, 32'd1);
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    #9 i_reset = 1'b1;
    @(negedge clock);
    check("post_rst_led", {28'd0, o_led}, 32'd1);
    check("post_rst_valid", {31'd0, o_valid}, 32'd0);
    // One edge already elapsed since release: full 32 from release.
    tick_and_step("post_rst", 31, 3'b001);

    // Rate 0 selected at the tick (counter 0): 256 edges total, one used by the step.
    tick_and_step("r0_first", 255, 3'b001);

    // Bring the counter to 50, then disable for 40 cycles.
    step(49);
    i_sw = 3'b000;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (o_valid === 1'b1) seen++;
    end
    check("off_no_tick", seen, 0);
    check("off_led_frozen", {28'd0, o_led}, {28'd0, exp_led});
    // Resume from 50: 205 edges to reach 255, one more to wrap.
    i_sw = 3'b001;
    tick_and_step("r0_resume", 206, 3'b001);

    // Counter to 100 at rate 0, then drop to limit 31: wrap on the next edge.
    step(99);
    i_sw = 3'b111;
    tick_and_step("lim_change", 1, 3'b111);
    tick_and_step("lim_after", 31, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_led_shift_counter
`default_nettype wire

// File: doc/led_shift_counter.md
Name: led_shift_counter

Overview:
- Switch-controlled LED chaser: a programmable-rate counter produces a one-cycle valid pulse, and each pulse rotates a one-hot LED pattern by one position.
- Top-level user-I/O block for board switches and LEDs.
- o_valid is also exported as the tick output for verification and for other consumers.

Parameters:
- NB_LEDS, 4, width of the LED register (must be at least 2).
- NB_SW, 3, width of the switch input: bit 0 is enable, bits 2:1 are rate select.
- NB_COUNTER, 8, width of the rate counter.
- R0_LIMIT, 2**NB_COUNTER-1 (255), terminal count for select 00.
- R1_LIMIT, 2**(NB_COUNTER-1)-1 (127), terminal count for select 01.
- R2_LIMIT, 2**(NB_COUNTER-2)-1 (63), terminal count for select 10.
- R3_LIMIT, 2**(NB_COUNTER-3)-1 (31), terminal count for select 11.

Ports:
- clock  in  1  single system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_sw  in  NB_SW  i_sw[0] = count enable; i_sw[2:1] = rate select.
- o_led  out  NB_LEDS  one-hot rotating LED pattern.
- o_valid  out  1  registered one-cycle tick.

Behaviour:
- Reset: i_reset=0 asynchronously forces counter=0, o_valid=0, o_led=0001 (bit 0 set), regardless of clock. Release is synchronous to the next rising edge.
- Limit select (combinational): limit = R0/R1/R2/R3_LIMIT for i_sw[2:1] = 00/01/10/11.
- Counter, at each rising edge:
  - i_sw[0]=0: counter holds, o_valid<=0.
  - i_sw[0]=1 and counter>=limit: counter<=0, o_valid<=1.
  - i_sw[0]=1 otherwise: counter<=counter+1, o_valid<=0.
- Tick timing: with enable held, o_valid is high for exactly 1 cycle every limit+1 cycles. The first tick after enabling from counter=0 appears limit+1 edges later.
- Using >= (not ==) means that switching to a smaller limit while counter exceeds it wraps on the next enabled edge. The counter never runs past limit.
- Disabling holds the counter value. Re-enabling resumes from the held value.
- Rotator, at each rising edge:
  - o_valid=1: o_led <= {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]} (rotate left).
  - Otherwise o_led holds.
  - The LED therefore moves on the edge after the tick edge (1-cycle latency from o_valid rising).
- Sequence for NB_LEDS=4: 0001 -> 0010 -> 0100 -> 1000 -> 0001 (wrap).
- o_led stays one-hot at all times. No path exists to load an arbitrary pattern.
- i_sw changes take effect at the next edge. No synchronizer is inside the block; switch debouncing and synchronization are done upstream.
- Reset asserted mid-operation: immediate return to reset values. The counter does not remember its phase.

Decomposition:
- Shared package: NB_LEDS/NB_SW/NB_COUNTER defaults, the rate-select encoding constants (SEL_R0..SEL_R3), the enable bit index, and the LED reset pattern constant.
- One sub-module, rate_counter: clock, i_reset, i_sw, o_valid, parameterized by NB_COUNTER and the four limits.
- The LED rotator stays inline in led_shift_counter.

Test Plan:
- Reset: hold i_reset=0 with clock running and i_sw=3'b111 -> o_led=0001, o_valid=0 throughout. Assert reset between edges -> outputs clear without waiting for an edge.
- Rate 3: release reset, i_sw=3'b111 (limit 31) -> o_valid pulses 1 cycle wide every 32 cycles. o_led steps 0010, 0100, 1000, 0001 one cycle after each of 4 pulses.
- Rate 0 / enable off:
  - i_sw=3'b001 (limit 255) -> first o_valid 256 edges after enabling.
  - i_sw=3'b000 -> no o_valid, o_led frozen, counter held.
  - Re-enable -> tick arrives after the remaining count.
- Limit change: run at select 00 until counter=100, switch to 11 (limit 31) -> o_valid on the next edge, counter=0, then every 32 cycles.
- Reset mid-run: after 2 LED steps (o_led=0100), pulse i_reset=0 for 10 time units -> o_led=0001, o_valid=0. After release, the next tick takes a full limit+1 cycles.
